// File: rtl/mux_led_selftest_seq.sv
// Self-test sequencer for the board's 4x1 LED mux. It sweeps {A,B,C,D}
// through all 16 combinations, waits for the fed-back F to settle, and
// compares F against the mux truth table. It reports busy/done/pass, the
// mismatch count and the first failing vector.
module mux_led_selftest_seq #(
  parameter int SETTLE_CYCLES = 4  // legal 3..255, because F passes a 2-flop synchronizer
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  output logic       sel_a,
  output logic       sel_b,
  output logic       dat_c,
  output logic       dat_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_fail_idx,
  output logic [3:0] vec_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic       s1, s2, s3;
  logic       f_meta, f_s;
  logic       start_pulse;
  logic       exp_f;
  logic       mismatch;

  // Synchronize the asynchronous start button and F feedback into clk.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge; with blocking ones s1->s2->s3 would
  // collapse into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      f_meta <= 1'b0;
      f_s    <= 1'b0;
    end else begin
      s1     <= start;
      s2     <= s1;
      s3     <= s2;
      f_meta <= f_in;
      f_s    <= f_meta;
    end
  end

  // A held start level produces a single pulse on its rising edge.
  assign start_pulse = s2 & ~s3;

  // Mux truth table for the vector under test: idx = {A,B,C,D}.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    exp_f = 1'b0;
    case (vec_idx[3:2])
      2'b00:   exp_f = vec_idx[1];
      2'b01:   exp_f = vec_idx[0];
      2'b10:   exp_f = ~vec_idx[1] | vec_idx[0];
      default: exp_f = 1'b0;
    endcase
  end

  assign mismatch = f_s ^ exp_f;

  // Sweep FSM with registered mux drive and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      settle_cnt     <= 8'd0;
      sel_a          <= 1'b0;
      sel_b          <= 1'b0;
      dat_c          <= 1'b0;
      dat_d          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= 5'd0;
      first_fail_idx <= 4'd0;
      vec_idx        <= 4'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_pulse) begin
            vec_idx        <= 4'd0;
            err_cnt        <= 5'd0;
            first_fail_idx <= 4'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            state          <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          {sel_a, sel_b, dat_c, dat_d} <= vec_idx;
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            // At most 16 vectors, so the 5-bit count cannot overflow.
            err_cnt <= err_cnt + 5'd1;
            if (err_cnt == 5'd0) begin
              first_fail_idx <= vec_idx;
            end
          end
          if (vec_idx == 4'd15) begin
            // vec_idx holds at 15 in DONE; the mux inputs return to 0.
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == 5'd0) && !mismatch;
            sel_a <= 1'b0;
            sel_b <= 1'b0;
            dat_c <= 1'b0;
            dat_d <= 1'b0;
            state <= ST_DONE;
          end else begin
            vec_idx <= vec_idx + 4'd1;
            state   <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_led_selftest_seq.sv
// Bench for mux_led_selftest_seq: a behavioural LED mux (optionally faulty)
// answers the DUT's drive; each sweep's expected report is queued when the
// run is issued and a monitor compares it when done rises.
module tb_mux_led_selftest_seq;

  localparam int SETTLE = 4;
  localparam int SWEEP_LEN = 16 * (SETTLE + 2);
  // Truth-table ones of the LED mux: vectors 2,3,5,7,8,9,11.
  localparam logic [15:0] GOLDEN_ONES = 16'h0BAC;

  typedef enum int {M_GOLDEN, M_ZERO, M_ONE, M_INV, M_MASK} mode_t;
  typedef struct {
    int err_cnt;
    int ffi;
    bit pass;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       f_in;
  logic       sel_a, sel_b, dat_c, dat_d;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] first_fail_idx;
  logic [3:0] vec_idx;

  mode_t       mode;
  logic [15:0] mask;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          runs_issued = 0;
  int          done_events = 0;

  mux_led_selftest_seq #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
    .sel_a(sel_a), .sel_b(sel_b), .dat_c(dat_c), .dat_d(dat_d),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit golden_f(input logic [3:0] idx);
    logic [15:0] g;
    g = GOLDEN_ONES;
    return g[idx];
  endfunction

  // Behaviour of the board mux under the selected fault.
  function automatic bit model_f(input mode_t m, input logic [15:0] msk, input logic [3:0] idx);
    case (m)
      M_ZERO:  return 1'b0;
      M_ONE:   return 1'b1;
      M_INV:   return ~golden_f(idx);
      M_MASK:  return golden_f(idx) ^ msk[idx];
      default: return golden_f(idx);
    endcase
  endfunction

  always_comb f_in = model_f(mode, mask, {sel_a, sel_b, dat_c, dat_d});

  // Expected report: walk all 16 vectors and compare the mux model to the table.
  function automatic exp_t predict(input mode_t m, input logic [15:0] msk);
    exp_t r;
    r.err_cnt = 0;
    r.ffi = 0;
    for (int i = 0; i < 16; i++) begin
      if (model_f(m, msk, 4'(i)) != golden_f(4'(i))) begin
        if (r.err_cnt == 0) r.ffi = i;
        r.err_cnt++;
      end
    end
    r.pass = (r.err_cnt == 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({sel_a, sel_b, dat_c, dat_d, busy, done, pass,
                     err_cnt, first_fail_idx, vec_idx}), 32'd0);
  endtask

  // Monitor: on each rising done, pop the expected report and compare.
  int busy_cnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !prev_done) begin
        done_events++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got a finished sweep, expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("err_cnt", 32'(err_cnt), 32'(e.err_cnt));
          check("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
          check("pass", 32'(pass), 32'(e.pass));
          check("sweep_len", 32'(busy_cnt), 32'(SWEEP_LEN));
          check("vec_idx_end", 32'(vec_idx), 32'd15);
          check("busy_in_done", 32'(busy), 32'd0);
          check("mux_zero_in_done", 32'({sel_a, sel_b, dat_c, dat_d}), 32'd0);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  // Issue one sweep: queue its expected report, raise start for `hold`
  // cycles, check the 2-edge start latency, optionally pulse start mid-sweep.
  task automatic run_sweep(input mode_t m, input logic [15:0] msk, input int hold,
                           input bit mid_pulse);
    int n;
    mode = m;
    mask = msk;
    exp_q.push_back(predict(m, msk));
    runs_issued++;
    @(negedge clk);
    start = 1'b1;
    n = (hold < 3) ? 3 : hold;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == hold - 1) start = 1'b0;
      if (k == 1) check("busy_before_edge2", 32'(busy), 32'd0);
      if (k == 2 && hold < SWEEP_LEN) begin
        check("busy_at_edge2", 32'(busy), 32'd1);
        check("done_drop", 32'(done), 32'd0);
        check("pass_drop", 32'(pass), 32'd0);
        check("err_cnt_clear", 32'(err_cnt), 32'd0);
      end
    end
    start = 1'b0;
    if (mid_pulse) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
    end
    wait_done(400);
    repeat (6) @(negedge clk);
    check("single_sweep_done_hold", 32'({done, busy}), 32'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end by itself");
    $fatal(1);
  end

  initial begin
    logic [15:0] rmask;
    int budget;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = M_GOLDEN;
    mask  = 16'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("idle_after_reset");

    run_sweep(M_GOLDEN, 16'd0, 10, 1'b0);
    run_sweep(M_ZERO, 16'd0, int'($urandom_range(1, 8)), 1'b0);
    run_sweep(M_ONE, 16'd0, int'($urandom_range(1, 8)), 1'b0);
    run_sweep(M_INV, 16'd0, int'($urandom_range(1, 8)), 1'b0);
    // Restart after a failing run, with a start pulse in mid-sweep.
    run_sweep(M_GOLDEN, 16'd0, int'($urandom_range(1, 8)), 1'b1);
    // Start held beyond the end of the sweep: still one sweep only.
    run_sweep(M_GOLDEN, 16'd0, SWEEP_LEN + 30, 1'b0);
    repeat (5) begin
      rmask = 16'($urandom());
      run_sweep(M_MASK, rmask, int'($urandom_range(1, 12)), 1'b0);
    end

    // Reset in mid-sweep at vector 6: no partial result survives.
    mode = M_GOLDEN;
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    budget = 0;
    while (vec_idx != 4'd6 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("reached_vec6", 32'(vec_idx), 32'd6);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_mid_sweep");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all_zero("idle_after_mid_reset");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("sweep_count", 32'(done_events), 32'(runs_issued));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
